// File: rtl/inst_prefetch_unit_if.sv
// Fetch-side bundle: redirect in, instruction-memory req/ack, core valid/ready out.
// No logic inside; timing is set entirely by inst_prefetch_unit.
// master = prefetch unit (drives mem_req/inst_*), slave = core plus memory side.
interface inst_prefetch_unit_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic [CW-1:0] fifo_count;

    modport master (
        input  redirect_valid, redirect_pc, mem_ack, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, fifo_count
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_ack, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, fifo_count
    );
endinterface

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetcher: word fetches over req/ack into a DEPTH-entry {pc,inst} FIFO.
// Latency: redirect at N -> mem_req on target at N+1 -> inst_valid at N+2 (zero-wait memory).
// Backpressure: inst_ready low fills the FIFO; a fetch is only issued when its slot is guaranteed.
module inst_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_prefetch_unit_if.master bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];

    logic          flush;
    logic          pop;
    logic          push;
    logic [31:0]   redir_tgt;
    logic [CW-1:0] cnt_after_pop;
    logic [CW-1:0] cnt_after_push;

    // FIFO handshakes; a redirect kills both push and pop in its cycle
    always_comb begin
        flush          = bus.redirect_valid;
        redir_tgt      = bus.redirect_pc & ~32'h3;
        pop            = (count_q != '0) && bus.inst_ready && !flush;
        push           = bus.mem_ack && (state_q == ST_REQ) && !flush;
        cnt_after_pop  = count_q - CW'(pop);
        cnt_after_push = cnt_after_pop + CW'(1);
    end

    // Fetch sequencer: IDLE waits for room, REQ fetches, DROP swallows a stale ack
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    mem_addr_d = redir_tgt;
                    fetch_pc_d = redir_tgt;
                    state_d    = ST_REQ;
                end else if (cnt_after_pop < DEPTH_C) begin
                    mem_addr_d = fetch_pc_q;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    if (flush) begin
                        mem_addr_d = redir_tgt;
                        fetch_pc_d = redir_tgt;
                    end else begin
                        // mem_addr tracks the next PC even when parking in IDLE
                        fetch_pc_d = mem_addr_q + 32'd4;
                        mem_addr_d = mem_addr_q + 32'd4;
                        if (!(cnt_after_push < DEPTH_C)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (flush) begin
                    fetch_pc_d = redir_tgt;
                    state_d    = ST_DROP;
                end
            end
            ST_DROP: begin
                if (flush) begin
                    fetch_pc_d = redir_tgt;
                end
                if (bus.mem_ack) begin
                    mem_addr_d = flush ? redir_tgt : fetch_pc_q;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_req_d = (state_d != ST_IDLE);
    end

    // FIFO pointer and occupancy update; flush wins over push/pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state with asynchronous reset; any in-flight fetch is abandoned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
            fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_pc    = fifo_pc_q[rd_ptr_q];
    assign bus.inst_data  = fifo_data_q[rd_ptr_q];
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Bench for inst_prefetch_unit: queue-based reference model compared every cycle.
// Directed scenarios (stream, backpressure, wait states, redirects, reset) then random traffic.
// Inputs driven on the falling edge; outputs compared on the following falling edge.
module tb_inst_prefetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset;

    inst_prefetch_unit_if #(.DEPTH(DEPTH)) ifc ();

    inst_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: buffered {pc,data}, outstanding fetch, whether its data is stale
    logic [63:0] mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_next;

    // Memory responder: ack after `waits` extra cycles of an outstanding request
    int waits = 0;
    int wcnt  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_addr = RESET_PC;
        m_next = RESET_PC;
        wcnt   = 0;
    endtask

    // One clock of fetch-unit behaviour, expressed on the queue
    task automatic model_update(input bit r, input logic [31:0] tgt, input bit ack, input bit rdy);
        bit pop;
        pop = (mq.size() != 0) && rdy && !r;
        if (r) mq.delete();
        else if (pop) void'(mq.pop_front());
        if (!m_busy) begin
            if (r) begin
                m_busy = 1'b1; m_addr = tgt; m_next = tgt;
            end else if (mq.size() < DEPTH) begin
                m_busy = 1'b1; m_addr = m_next;
            end
        end else if (!m_drop) begin
            if (ack && !r) begin
                mq.push_back({m_addr, mem_word(m_addr)});
                m_next = m_addr + 32'd4;
                m_addr = m_addr + 32'd4;
                if (mq.size() >= DEPTH) m_busy = 1'b0;
            end else if (ack && r) begin
                m_addr = tgt;
            end else if (r) begin
                m_drop = 1'b1; m_next = tgt;
            end
        end else begin
            if (r) m_next = tgt;
            if (ack) begin
                m_drop = 1'b0; m_addr = m_next;
            end
        end
    endtask

    task automatic compare();
        chk("mem_req", 32'(ifc.mem_req), 32'(m_busy));
        chk("mem_addr", ifc.mem_addr, m_addr);
        chk("fifo_count", 32'(ifc.fifo_count), 32'(mq.size()));
        chk("inst_valid", 32'(ifc.inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_pc", ifc.inst_pc, mq[0][63:32]);
            chk("inst_data", ifc.inst_data, mq[0][31:0]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance model, check next falling edge
    task automatic step(input bit r, input logic [31:0] rpc, input bit rdy);
        bit ack;
        ack = m_busy && (wcnt >= waits);
        if (m_busy) wcnt = ack ? 0 : wcnt + 1;
        ifc.redirect_valid = r;
        ifc.redirect_pc    = rpc;
        ifc.inst_ready     = rdy;
        ifc.mem_ack        = ack;
        ifc.mem_rdata      = mem_word(ifc.mem_addr);
        model_update(r, rpc & ~32'h3, ack, rdy);
        @(negedge clk);
        compare();
    endtask

    // Run until a fresh (non-stale) request to `a` has seen `w` wait cycles
    task automatic wait_fetch(input logic [31:0] a, input int w);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (m_busy && !m_drop && m_addr == a && wcnt == w) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1);
        end
        chk("wait_fetch_found", 32'(found), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset              = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        ifc.mem_ack        = 1'b0;
        ifc.mem_rdata      = '0;
        ifc.inst_ready     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_mem_req", 32'(ifc.mem_req), 32'd0);
        chk("rst_mem_addr", ifc.mem_addr, 32'h0);
        chk("rst_fifo_count", 32'(ifc.fifo_count), 32'd0);
        chk("rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
        compare();
        reset = 1'b1;

        // Stream with zero-wait memory
        step(1'b0, 32'h0, 1'b1);
        chk("stream_first_addr", ifc.mem_addr, 32'h0);
        chk("stream_first_req", 32'(ifc.mem_req), 32'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("stream_pc0", ifc.inst_pc, 32'h0);
        chk("stream_data0", ifc.inst_data, 32'h1234_5678);
        step(1'b0, 32'h0, 1'b1);
        chk("stream_pc4", ifc.inst_pc, 32'h4);
        chk("stream_addr8", ifc.mem_addr, 32'h8);
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // Address wrap past the top of memory; low target bits are ignored
        step(1'b1, 32'hFFFF_FFFA, 1'b1);
        chk("wrap_target", ifc.mem_addr, 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap_addr0", ifc.mem_addr, 32'h0);
        chk("wrap_pc", ifc.inst_pc, 32'hFFFF_FFFC);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // Backpressure: fill, stall, then drain in order
        step(1'b1, 32'h200, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b0);
        chk("bp_full_count", 32'(ifc.fifo_count), 32'd4);
        chk("bp_req_low", 32'(ifc.mem_req), 32'd0);
        chk("bp_next_addr", ifc.mem_addr, 32'h210);
        chk("bp_head", ifc.inst_pc, 32'h200);
        step(1'b0, 32'h0, 1'b1);
        chk("bp_resume_head", ifc.inst_pc, 32'h204);
        chk("bp_resume_req", 32'(ifc.mem_req), 32'd1);
        chk("bp_resume_addr", ifc.mem_addr, 32'h210);
        chk("bp_resume_count", 32'(ifc.fifo_count), 32'd3);
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Wait states: three extra cycles per fetch
        step(1'b1, 32'h300, 1'b1);
        waits = 3;
        repeat (3) step(1'b0, 32'h0, 1'b1);
        chk("ws_addr_held", ifc.mem_addr, 32'h300);
        chk("ws_req_held", 32'(ifc.mem_req), 32'd1);
        chk("ws_not_yet", 32'(ifc.inst_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("ws_arrive", ifc.inst_pc, 32'h300);
        repeat (16) step(1'b0, 32'h0, 1'b1);

        // Redirect while the fetch to 8 is pending: its late ack must be dropped
        step(1'b1, 32'h0, 1'b1);
        wait_fetch(32'h8, 0);
        step(1'b1, 32'h40, 1'b1);
        chk("drop_addr_held", ifc.mem_addr, 32'h8);
        chk("drop_req_held", 32'(ifc.mem_req), 32'd1);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        chk("drop_new_addr", ifc.mem_addr, 32'h40);
        chk("drop_no_push", 32'(ifc.fifo_count), 32'd0);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        chk("drop_first_pc", ifc.inst_pc, 32'h40);

        // Redirect in the same cycle as the ack for 0xC
        step(1'b1, 32'h0, 1'b1);
        wait_fetch(32'hC, 3);
        step(1'b1, 32'h103, 1'b1);
        chk("sim_addr", ifc.mem_addr, 32'h100);
        chk("sim_flushed", 32'(ifc.fifo_count), 32'd0);
        chk("sim_invalid", 32'(ifc.inst_valid), 32'd0);
        repeat (4) step(1'b0, 32'h0, 1'b1);
        chk("sim_first_pc", ifc.inst_pc, 32'h100);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            if (wcnt == 0 && $urandom_range(0, 15) == 0) waits = $urandom_range(0, 2);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        // Reset with three entries buffered and a fetch outstanding
        waits = 0;
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h500, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        chk("mid_count3", 32'(ifc.fifo_count), 32'd3);
        chk("mid_pending", 32'(ifc.mem_req), 32'd1);
        chk("mid_addr", ifc.mem_addr, 32'h50C);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ifc.inst_valid), 32'd0);
        chk("mid_rst_req", 32'(ifc.mem_req), 32'd0);
        chk("mid_rst_count", 32'(ifc.fifo_count), 32'd0);
        chk("mid_rst_addr", ifc.mem_addr, RESET_PC);
        model_reset();
        ifc.mem_ack        = 1'b0;
        ifc.redirect_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        chk("post_rst_addr", ifc.mem_addr, RESET_PC);
        chk("post_rst_req", 32'(ifc.mem_req), 32'd1);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
